// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard and sequential clear sweep.
// Optional same-cycle write-to-read bypass under REGFILE_MP_BYPASS_EN.
module regfile_mp #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NR    = 2,
  parameter  int NW    = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NR*AW-1:0]  i_rs_addr,
  output logic [NR*XLEN-1:0] o_rs_data,
  output logic [NR-1:0]     o_rs_busy,
  input  logic [NW-1:0]     i_rd_wren,
  input  logic [NW*AW-1:0]  i_rd_addr,
  input  logic [NW*XLEN-1:0] i_rd_data,
  input  logic              i_alloc_en,
  input  logic [AW-1:0]     i_alloc_addr,
  input  logic              i_clear_req,
  output logic              o_clear_busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;
  state_e                     state_q, state_d;
  logic [AW-1:0]              cnt_q, cnt_d;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      regs_q  <= '0;
      busy_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= ONE;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // ascending port order lets the highest port win on collisions
        for (int w = 0; w < NW; w++) begin
          if (i_rd_wren[w] && (i_rd_addr[w*AW +: AW] != '0)) begin
            regs_d[i_rd_addr[w*AW +: AW]] = i_rd_data[w*XLEN +: XLEN];
            busy_d[i_rd_addr[w*AW +: AW]] = 1'b0;
          end
        end
        if (i_alloc_en && (i_alloc_addr != '0)) begin
          busy_d[i_alloc_addr] = 1'b1;
        end
        if (i_clear_req) begin
          state_d = SWEEP;
          cnt_d   = ONE;
        end
      end
      SWEEP: begin
        regs_d[cnt_q] = '0;
        busy_d[cnt_q] = 1'b0;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = ONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    o_rs_data = '0;
    o_rs_busy = '0;
    for (int k = 0; k < NR; k++) begin
      o_rs_data[k*XLEN +: XLEN] = regs_q[i_rs_addr[k*AW +: AW]];
      o_rs_busy[k] = busy_q[i_rs_addr[k*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
      if ((state_q == IDLE) && (i_rs_addr[k*AW +: AW] != '0)) begin
        for (int w = 0; w < NW; w++) begin
          if (i_rd_wren[w] &&
              (i_rd_addr[w*AW +: AW] == i_rs_addr[k*AW +: AW])) begin
            o_rs_data[k*XLEN +: XLEN] = i_rd_data[w*XLEN +: XLEN];
          end
        end
      end
`endif
    end
  end

  assign o_clear_busy = (state_q == SWEEP);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and random checks of regfile_mp against an array-based model.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int AW    = 5;

  logic              clk;
  logic              rst_n;
  logic [NR*AW-1:0]  rs_addr;
  logic [NR*XLEN-1:0] rs_data;
  logic [NR-1:0]     rs_busy;
  logic [NW-1:0]     wren;
  logic [NW*AW-1:0]  waddr;
  logic [NW*XLEN-1:0] wdata;
  logic              alloc_en;
  logic [AW-1:0]     alloc_addr;
  logic              clear_req;
  logic              clear_busy;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NR(NR), .NW(NW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_rs_addr   (rs_addr),
    .o_rs_data   (rs_data),
    .o_rs_busy   (rs_busy),
    .i_rd_wren   (wren),
    .i_rd_addr   (waddr),
    .i_rd_data   (wdata),
    .i_alloc_en  (alloc_en),
    .i_alloc_addr(alloc_addr),
    .i_clear_req (clear_req),
    .o_clear_busy(clear_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // model: register values, busy flags, and cycles of sweep remaining
  logic [XLEN-1:0] mregs [NREGS];
  bit              mbusy [NREGS];
  int              sweep_left;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) begin
      mregs[i] = '0;
      mbusy[i] = 1'b0;
    end
    sweep_left = 0;
  endfunction

  function automatic void model_step();
    int a;
    if (sweep_left > 0) begin
      a = NREGS - sweep_left;
      mregs[a] = '0;
      mbusy[a] = 1'b0;
      sweep_left--;
    end else begin
      for (int w = 0; w < NW; w++) begin
        a = int'(waddr[w*AW +: AW]);
        if (wren[w] && a != 0) begin
          mregs[a] = wdata[w*XLEN +: XLEN];
          mbusy[a] = 1'b0;
        end
      end
      if (alloc_en && alloc_addr != 0) mbusy[alloc_addr] = 1'b1;
      if (clear_req) sweep_left = NREGS - 1;
    end
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int a);
    logic [XLEN-1:0] v;
    v = mregs[a];
`ifdef REGFILE_MP_BYPASS_EN
    if (sweep_left == 0 && a != 0)
      for (int w = 0; w < NW; w++)
        if (wren[w] && int'(waddr[w*AW +: AW]) == a)
          v = wdata[w*XLEN +: XLEN];
`endif
    return v;
  endfunction

  task automatic check_reads(input string tag);
    int a;
    #1;
    for (int k = 0; k < NR; k++) begin
      a = int'(rs_addr[k*AW +: AW]);
      chk({tag, "_data"}, 64'(rs_data[k*XLEN +: XLEN]), 64'(exp_data(a)));
      chk({tag, "_busy"}, 64'(rs_busy[k]), 64'(mbusy[a]));
    end
    chk({tag, "_cbusy"}, 64'(clear_busy), 64'(sweep_left > 0));
  endtask

  task automatic idle_in();
    wren = '0; waddr = '0; wdata = '0;
    alloc_en = 1'b0; alloc_addr = '0; clear_req = 1'b0;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
    wren[p] = 1'b1;
    waddr[p*AW +: AW] = AW'(a);
    wdata[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int a0, input int a1);
    rs_addr[0 +: AW] = AW'(a0);
    rs_addr[AW +: AW] = AW'(a1);
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < NREGS; i += 2) begin
      rd(i, i + 1);
      check_reads(tag);
    end
  endtask

  task automatic preload();
    for (int i = 1; i < NREGS; i += 2) begin
      wr(0, i, XLEN'(i));
      if (i + 1 < NREGS) wr(1, i + 1, XLEN'(i + 1));
      cyc();
    end
  endtask

  int n;

  initial begin
    idle_in();
    rs_addr = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    rd(0, 5);
    check_reads("reset");
    check_all_regs("reset_all");

    // write to x0 is discarded
    wr(0, 0, 32'hDEADBEEF);
    rd(0, 0);
    check_reads("x0_wr");
    cyc();
    rd(0, 0);
    check_reads("x0_after");
    chk("x0_val", 64'(rs_data[XLEN-1:0]), 64'h0);

    // same-address collision: highest port wins
    wr(0, 7, 32'h11111111);
    wr(1, 7, 32'h22222222);
    cyc();
    rd(7, 0);
    check_reads("collide");
    chk("collide_val", 64'(rs_data[XLEN-1:0]), 64'h22222222);

    // scoreboard
    alloc_en = 1'b1; alloc_addr = 9;
    cyc();
    rd(9, 9);
    check_reads("alloc");
    chk("alloc_busy", 64'(rs_busy[0]), 64'h1);
    wr(0, 9, 32'h5);
    cyc();
    check_reads("wr_clr");
    chk("wr_clr_busy", 64'(rs_busy[1]), 64'h0);
    wr(1, 9, 32'h6);
    alloc_en = 1'b1; alloc_addr = 9;
    cyc();
    check_reads("alloc_wr");
    chk("alloc_wr_busy", 64'(rs_busy[0]), 64'h1);
    alloc_en = 1'b1; alloc_addr = 0;
    cyc();
    rd(0, 0);
    check_reads("alloc_x0");

    // bypass / visibility timing on x3
    wr(0, 3, 32'h00000033);
    cyc();
    rd(3, 3);
    wr(1, 3, 32'hCAFE0003);
`ifdef REGFILE_MP_BYPASS_EN
    #1 chk("byp_same", 64'(rs_data[XLEN-1:0]), 64'hCAFE0003);
`else
    #1 chk("nobyp_same", 64'(rs_data[XLEN-1:0]), 64'h00000033);
`endif
    check_reads("byp");
    cyc();
    check_reads("byp_next");
    chk("byp_next_val", 64'(rs_data[XLEN+:XLEN]), 64'hCAFE0003);

    // full clear sweep
    preload();
    for (int i = 1; i < NREGS; i += 4) begin
      alloc_en = 1'b1; alloc_addr = AW'(i);
      cyc();
    end
    check_all_regs("preload");
    clear_req = 1'b1;
    check_reads("req");
    cyc();
    n = 0;
    while (clear_busy === 1'b1 && n < 100) begin
      n++;
      if (n == 5) begin
        wr(1, 31, 32'hBAD0001F);
        alloc_en = 1'b1; alloc_addr = 31;
        clear_req = 1'b1;
      end
      rd(n, 31);
      check_reads("sweep");
      cyc();
    end
    chk("sweep_len", 64'(n), 64'd31);
    check_all_regs("swept");

    // reset mid-sweep
    preload();
    clear_req = 1'b1;
    cyc();
    repeat (9) cyc();
    rd(25, 30);
    check_reads("pre_abort");
    rst_n = 1'b0;
    model_reset();
    #1 chk("abort_cbusy", 64'(clear_busy), 64'h0);
    check_all_regs("abort");
    #2 rst_n = 1'b1;
    wr(0, 12, 32'h0BADCAFE);
    cyc();
    rd(12, 0);
    check_reads("post_rst");
    chk("post_rst_val", 64'(rs_data[XLEN-1:0]), 64'h0BADCAFE);

    // random traffic
    for (int t = 0; t < 600; t++) begin
      for (int w = 0; w < NW; w++) begin
        wren[w] = 1'($urandom_range(0, 1));
        waddr[w*AW +: AW] = ($urandom_range(0, 3) == 0) ?
          AW'($urandom_range(0, 3)) : AW'($urandom);
        wdata[w*XLEN +: XLEN] = $urandom;
      end
      alloc_en = 1'($urandom_range(0, 1));
      alloc_addr = AW'($urandom);
      clear_req = ($urandom_range(0, 60) == 0);
      rs_addr = ($urandom_range(0, 2) == 0) ? {waddr[AW +: AW], waddr[0 +: AW]}
                                             : (NR*AW)'($urandom);
      check_reads("rand");
      cyc();
    end
    check_all_regs("final");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file. Successor to the single-write, dual-read RV32I register file.
- Configurable width, depth, read-port count and write-port count.
- Adds a per-register busy scoreboard for the issue stage.
- Adds a multi-cycle sequential clear sweep for pipeline flush or context reset.
- Sits between decode/issue (reads, allocation) and writeback (writes) in the pipeline.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, >= 4. Register 0 is hardwired to zero.
- NR, 2, number of read ports.
- NW, 2, number of write ports.
- AW, $clog2(NREGS), address width. Derived; not overridden.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous active-low reset.
- i_rs_addr  in  NR*AW  read addresses; port k uses bits [k*AW +: AW].
- o_rs_data  out  NR*XLEN  read data, combinational; port k uses bits [k*XLEN +: XLEN].
- o_rs_busy  out  NR  busy flag of the register addressed by read port k.
- i_rd_wren  in  NW  write enable per write port.
- i_rd_addr  in  NW*AW  write addresses.
- i_rd_data  in  NW*XLEN  write data.
- i_alloc_en  in  1  mark a register busy (a producer has been issued).
- i_alloc_addr  in  AW  register to mark busy.
- i_clear_req  in  1  one-cycle pulse that starts the clear sweep.
- o_clear_busy  out  1  high while the sweep runs.

Behaviour:
- Reset (asynchronous, active-low):
  - All registers = 0, all busy bits = 0.
  - FSM = IDLE, sweep counter = 1, o_clear_busy = 0.
  - Asserting reset mid-sweep aborts the sweep immediately; the same values apply.
- Reads:
  - Combinational, from stored state.
  - Address 0 always returns 0 with busy = 0.
  - Any read port may address any register; all ports are independent.
- Writes (FSM IDLE only):
  - On the clock edge, each port with i_rd_wren=1 and i_rd_addr!=0 writes i_rd_data.
  - Writes to address 0 are discarded.
  - Two or more ports writing the same address in one cycle: the highest-indexed port wins, deterministically.
- Scoreboard:
  - A write to register r (addr != 0) clears busy[r].
  - i_alloc_en sets busy[i_alloc_addr]. Allocation of address 0 is ignored.
  - Alloc and write to the same register in one cycle: busy ends at 1, because the new producer takes precedence.
  - o_rs_busy reflects registered busy state only; it is not bypassed.
- Clear FSM:
  - IDLE: i_clear_req=1 -> SWEEP, counter = 1.
  - SWEEP: each cycle writes 0 to register[counter], clears busy[counter], then increments the counter.
  - When the counter reaches NREGS-1, that register is cleared and the FSM returns to IDLE.
  - The sweep lasts exactly NREGS-1 cycles.
  - o_clear_busy = 1 in SWEEP; it is registered, so it goes high the cycle after the request.
- During SWEEP:
  - All write-port writes and allocations are ignored.
  - Reads still return current stored contents: already-swept entries read 0, unswept entries keep their old values.
  - i_clear_req is ignored; no restart.
- Counter width is AW; it never wraps, because the exit happens at NREGS-1.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined:
  - A read whose address (!= 0) matches an enabled write in the same cycle returns that write data combinationally.
  - If several ports match, the highest-indexed port's data is returned.
  - Bypass is suppressed during SWEEP, since writes are ignored there.
- Undefined:
  - Reads return stored state only; a write becomes visible the cycle after the edge.
  - Matches plain flop-array timing.

Test Plan:
- Reset, then read x0 and x5 -> both 0, busy 0. Write port 0 writes x0=0xDEADBEEF -> x0 still reads 0.
- Same cycle: port 0 writes x7=0x11111111 and port 1 writes x7=0x22222222 -> the following cycle x7 reads 0x22222222.
- Alloc x9 -> o_rs_busy=1 next cycle. Write x9=0x5 -> busy=0 next cycle. Alloc and write x9 in the same cycle -> busy=1.
- Preload x1..x31=index. Pulse i_clear_req -> o_clear_busy high for exactly 31 cycles. A write to x31 during the sweep is ignored. Afterwards all registers read 0 and all busy bits are 0.
- Assert reset at sweep cycle 10 -> o_clear_busy=0 immediately and all registers 0. A new write after reset release succeeds.
- With REGFILE_MP_BYPASS_EN: read x3 while port 1 writes x3=0xCAFE0003 -> o_rs_data=0xCAFE0003 in the same cycle. Without the macro: old value in the same cycle, new value the next cycle.
